// File: rtl/systolic_skew_feeder_if.sv
// Handshake and output bundle between a column-vector source, the skew feeder and a systolic array.
// L lanes of W-bit FP16 bit patterns on both the input and the skewed output side.
interface systolic_skew_feeder_if #(
    parameter int L = 4,
    parameter int W = 16
);
    logic         in_valid;
    logic [W-1:0] in_data [0:L-1];
    logic         in_last;
    logic         in_ready;
    logic         hold;
    logic [W-1:0] a_out [0:L-1];
    logic         a_en;
    logic         busy;
    logic         done;
    logic [7:0]   vec_count;

    modport master (
        output in_valid, in_data, in_last, hold,
        input  in_ready, a_out, a_en, busy, done, vec_count
    );

    modport slave (
        input  in_valid, in_data, in_last, hold,
        output in_ready, a_out, a_en, busy, done, vec_count
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skews column vectors into a systolic array: lane i is delayed by i advances, then zero-drained.
// Optional macro FEEDER_SUBNORMAL_FLUSH_EN flushes subnormal/zero-exponent inputs to +0.
module systolic_skew_feeder #(
    parameter int L = 4,
    parameter int W = 16
) (
    input logic               clk,
    input logic               reset,
    systolic_skew_feeder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    // Drain ends on the advance where the counter reaches L-2 (i.e. the (L-1)th drain advance).
    localparam logic [4:0] DRAIN_END = 5'(L > 1 ? L - 2 : 0);

    state_t              state, state_nxt;
    logic [4:0]          drain_cnt, drain_cnt_nxt;
    logic                ready;
    logic                accept;
    logic                advance;
    logic [L-1:0][W-1:0] lane_in;
    logic [L-1:0][W-1:0] lane_tail;

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        ready         = 1'b0;
        accept        = 1'b0;
        advance       = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE, FEED: begin
                ready    = reset && !bus.hold;
                bus.busy = (state == FEED);
                accept   = bus.in_valid && ready;
                advance  = accept;
                if (accept) begin
                    if (bus.in_last) begin
                        state_nxt     = (L == 1) ? DONE : DRAIN;
                        drain_cnt_nxt = '0;
                    end else begin
                        state_nxt = FEED;
                    end
                end
            end
            DRAIN: begin
                bus.busy = 1'b1;
                advance  = !bus.hold;
                if (advance) begin
                    drain_cnt_nxt = drain_cnt + 5'd1;
                    if (drain_cnt == DRAIN_END) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        bus.in_ready = ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            drain_cnt     <= '0;
            bus.a_en      <= 1'b0;
            bus.done      <= 1'b0;
            bus.vec_count <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            bus.a_en  <= advance;
            bus.done  <= (state == DONE);
            if (accept) begin
                bus.vec_count <= (state == IDLE) ? 8'd1 : bus.vec_count + 8'd1;
            end
        end
    end

    // Drain advances push zeros; only an accepted vector feeds real data into the lanes.
    always_comb begin
        for (int i = 0; i < L; i++) begin
            lane_in[i] = '0;
            if (accept) begin
`ifdef FEEDER_SUBNORMAL_FLUSH_EN
                if (bus.in_data[i][14:10] != 5'd0) begin
                    lane_in[i] = bus.in_data[i];
                end
`else
                lane_in[i] = bus.in_data[i];
`endif
            end
        end
    end

    for (genvar g = 0; g < L; g++) begin : g_lane
        if (g == 0) begin : g_direct
            assign lane_tail[g] = lane_in[g];
        end else begin : g_delay
            logic [W-1:0] line [0:g-1];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int j = 0; j < g; j++) begin
                        line[j] <= '0;
                    end
                end else if (advance) begin
                    line[0] <= lane_in[g];
                    for (int j = 1; j < g; j++) begin
                        line[j] <= line[j-1];
                    end
                end
            end

            assign lane_tail[g] = line[g-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < L; i++) begin
                bus.a_out[i] <= '0;
            end
        end else if (advance) begin
            for (int i = 0; i < L; i++) begin
                bus.a_out[i] <= lane_tail[i];
            end
        end
    end
endmodule
